// File: rtl/dma_cmd_issuer.sv
// Command issuer for the tiny DMA core: buffers 7-bit transfer commands in a FIFO
// and issues them one at a time as a start strobe on cfg_out, then waits for done or timeout.
module dma_cmd_issuer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [6:0]                  cmd_data,
  input  logic                        clear_err,
  input  logic                        dma_done_in,
  output logic [7:0]                  cfg_out,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [7:0]                  done_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

  state_e        state_q;
  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [7:0]    cfg_q;
  logic [7:0]    timer_q;
  logic [7:0]    done_cnt_q;
  logic          err_q;
  logic          push;
  logic          pop;

  // Ready depends only on the registered level, so a pop in the same cycle never frees a slot early.
  always_comb begin
    push    = cmd_valid && (level_q != FULL_LEVEL);
    pop     = (state_q == IDLE) && (level_q != '0);
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      timer_q    <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (clear_err) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            cfg_q   <= {1'b1, mem_q[rd_ptr_q]};
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cfg_q[7] <= 1'b0;
          timer_q  <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_q + 8'd1;
          // Done takes priority over a timeout landing on the same cycle.
          if (dma_done_in) begin
            done_cnt_q <= done_cnt_q + 8'd1;
            state_q    <= GAP;
          end else if (timer_q == TIMER_LAST) begin
            err_q   <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (level_q != FULL_LEVEL);
  assign cfg_out     = cfg_q;
  assign busy        = (state_q != IDLE) || (level_q != '0);
  assign timeout_err = err_q;
  assign done_count  = done_cnt_q;
  assign fifo_level  = level_q;

endmodule
